collapsing_issue_queue: RTL and testbench

Parametrised, age-ordered collapsing issue queue with tag-based wakeup, sitting between rename/dispatch and the two execution pipes. Accepts up to two instructions per cycle with source tags, wakes sources from two writeback broadcast buses, and issues up to two ready entries per cycle, oldest first. Surviving entries compact toward slot 0 every cycle, so slot index equals age order. Successor of the fixed 7-entry, readiness-blind shifting queue.

---
 rtl/iq_pkg.sv | 34 +++
 rtl/iq_pick2.sv | 30 +++
 rtl/collapsing_issue_queue.sv | 141 ++++++++++++++
 tb/tb_collapsing_issue_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared defaults and entry layout for the collapsing issue queue.
// Entry packing, LSB first: valid, payload, src1 tag, src1 rdy, src2 tag, src2 rdy.
package iq_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 6;

    localparam int VALID_OFS = 0;
    localparam int DATA_OFS  = 1;

    function automatic int entry_w(input int dw, input int tw);
        return 1 + dw + 2 * (tw + 1);
    endfunction

    function automatic int src1_tag_ofs(input int dw);
        return 1 + dw;
    endfunction

    function automatic int src1_rdy_ofs(input int dw, input int tw);
        return 1 + dw + tw;
    endfunction

    function automatic int src2_tag_ofs(input int dw, input int tw);
        return 2 + dw + tw;
    endfunction

    function automatic int src2_rdy_ofs(input int dw, input int tw);
        return 2 + dw + 2 * tw;
    endfunction

    localparam int ENTRY_W = entry_w(DATA_W_DEF, TAG_W_DEF);

endpackage

// File: rtl/iq_pick2.sv
// Finds the first and second set bits of a request vector, scanning from the LSB.
module iq_pick2 #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_vec,
    output logic [N-1:0] gnt0,
    output logic [N-1:0] gnt1,
    output logic         vld0,
    output logic         vld1
);

    always_comb begin
        gnt0 = '0;
        gnt1 = '0;
        vld0 = 1'b0;
        vld1 = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_vec[i]) begin
                if (!vld0) begin
                    gnt0[i] = 1'b1;
                    vld0    = 1'b1;
                end else if (!vld1) begin
                    gnt1[i] = 1'b1;
                    vld1    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/collapsing_issue_queue.sv
// Age-ordered collapsing issue queue: dual dispatch, tag wakeup from two buses,
// dual oldest-first issue. Survivors compact toward slot 0 so index equals age.
module collapsing_issue_queue
    import iq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          in_valid,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic [2*TAG_W-1:0]  in_src1_tag,
    input  logic [2*TAG_W-1:0]  in_src2_tag,
    input  logic [1:0]          in_src1_rdy,
    input  logic [1:0]          in_src2_rdy,
    output logic [1:0]          in_ready,
    input  logic [1:0]          wb_valid,
    input  logic [2*TAG_W-1:0]  wb_tag,
    output logic [1:0]          iss_valid,
    output logic [2*DATA_W-1:0] iss_data,
    input  logic [1:0]          iss_ready,
    output logic [CNT_W-1:0]    count
);

    localparam int EW   = entry_w(DATA_W, TAG_W);
    localparam int O_V  = VALID_OFS;
    localparam int O_D  = DATA_OFS;
    localparam int O_T1 = src1_tag_ofs(DATA_W);
    localparam int O_R1 = src1_rdy_ofs(DATA_W, TAG_W);
    localparam int O_T2 = src2_tag_ofs(DATA_W, TAG_W);
    localparam int O_R2 = src2_rdy_ofs(DATA_W, TAG_W);

    function automatic logic tag_hit(input logic [TAG_W-1:0]   tag,
                                     input logic [1:0]         v,
                                     input logic [2*TAG_W-1:0] tags);
        return (v[0] && (tags[0 +: TAG_W] == tag)) ||
               (v[1] && (tags[TAG_W +: TAG_W] == tag));
    endfunction

    logic [EW-1:0]    ent_q [DEPTH];
    logic [EW-1:0]    ent_d [DEPTH];
    logic [EW-1:0]    woke  [DEPTH];
    logic [EW-1:0]    new_e [2];
    logic [DEPTH-1:0] rdy_vec, remove, gnt0, gnt1;
    logic             pick_v0, pick_v1, acc0, acc1;
    logic [1:0]       n_acc, n_iss;
    logic [CNT_W-1:0] count_q, count_d;
    int               surv;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy_vec[i] = ent_q[i][O_V] & ent_q[i][O_R1] & ent_q[i][O_R2];
    end

    iq_pick2 #(.N(DEPTH)) u_pick (
        .req_vec (rdy_vec),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .vld0    (pick_v0),
        .vld1    (pick_v1)
    );

    assign iss_valid   = {pick_v1, pick_v0};
    assign count       = count_q;
    // Admission looks only at the registered count, never at same-cycle issue.
    assign in_ready[0] = (count_q <= CNT_W'(DEPTH - 1));
    assign in_ready[1] = (count_q <= CNT_W'(DEPTH - 2));
    assign acc0        = in_valid[0] & in_ready[0];
    assign acc1        = in_valid[1] & in_valid[0] & in_ready[1];
    assign remove      = (gnt0 & {DEPTH{iss_ready[0]}}) | (gnt1 & {DEPTH{iss_ready[1]}});
    assign n_iss       = {1'b0, pick_v0 & iss_ready[0]} + {1'b0, pick_v1 & iss_ready[1]};
    assign n_acc       = {1'b0, acc0} + {1'b0, acc1};
    assign count_d     = count_q + CNT_W'(n_acc) - CNT_W'(n_iss);

    always_comb begin
        iss_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_data[0 +: DATA_W]      = iss_data[0 +: DATA_W] |
                                         (ent_q[i][O_D +: DATA_W] & {DATA_W{gnt0[i]}});
            iss_data[DATA_W +: DATA_W] = iss_data[DATA_W +: DATA_W] |
                                         (ent_q[i][O_D +: DATA_W] & {DATA_W{gnt1[i]}});
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]       = ent_q[i];
            woke[i][O_R1] = ent_q[i][O_R1] | tag_hit(ent_q[i][O_T1 +: TAG_W], wb_valid, wb_tag);
            woke[i][O_R2] = ent_q[i][O_R2] | tag_hit(ent_q[i][O_T2 +: TAG_W], wb_valid, wb_tag);
        end
    end

    // Incoming slots see the same broadcasts, so a matching source lands already ready.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            new_e[k]                 = '0;
            new_e[k][O_V]            = 1'b1;
            new_e[k][O_D +: DATA_W]  = in_data[k*DATA_W +: DATA_W];
            new_e[k][O_T1 +: TAG_W]  = in_src1_tag[k*TAG_W +: TAG_W];
            new_e[k][O_T2 +: TAG_W]  = in_src2_tag[k*TAG_W +: TAG_W];
            new_e[k][O_R1]           = in_src1_rdy[k] |
                                       tag_hit(in_src1_tag[k*TAG_W +: TAG_W], wb_valid, wb_tag);
            new_e[k][O_R2]           = in_src2_rdy[k] |
                                       tag_hit(in_src2_tag[k*TAG_W +: TAG_W], wb_valid, wb_tag);
        end
    end

    always_comb begin
        surv = 0;
        for (int j = 0; j < DEPTH; j++)
            ent_d[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i][O_V] && !remove[i]) begin
                for (int j = 0; j < DEPTH; j++)
                    if (j == surv) ent_d[j] = woke[i];
                surv = surv + 1;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (acc0 && (j == surv))     ent_d[j] = new_e[0];
            if (acc1 && (j == surv + 1)) ent_d[j] = new_e[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int j = 0; j < DEPTH; j++)
                ent_q[j] <= '0;
            count_q <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++)
                ent_q[j] <= ent_d[j];
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_collapsing_issue_queue.sv
// Testbench for collapsing_issue_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_collapsing_issue_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            reset, flush;
    logic [1:0]      in_valid, in_src1_rdy, in_src2_rdy, in_ready;
    logic [2*DW-1:0] in_data, iss_data;
    logic [2*TW-1:0] in_src1_tag, in_src2_tag, wb_tag;
    logic [1:0]      wb_valid, iss_valid, iss_ready;
    logic [CW-1:0]   count;

    collapsing_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_src1_tag (in_src1_tag),
        .in_src2_tag (in_src2_tag),
        .in_src1_rdy (in_src1_rdy),
        .in_src2_rdy (in_src2_rdy),
        .in_ready    (in_ready),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .iss_valid   (iss_valid),
        .iss_data    (iss_data),
        .iss_ready   (iss_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] t1;
        logic          r1;
        logic [TW-1:0] t2;
        logic          r2;
    } ent_t;

    ent_t q[$];
    bit   model_ok = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit wbHit(input logic [TW-1:0] tag);
        return (wb_valid[0] && wb_tag[TW-1:0] == tag) || (wb_valid[1] && wb_tag[2*TW-1:TW] == tag);
    endfunction

    // Model outputs: oldest ready entry to port 0, next oldest to port 1.
    task automatic checkOutput();
        int p0 = -1;
        int p1 = -1;
        if (!model_ok) return;
        foreach (q[i])
            if (q[i].r1 && q[i].r2) begin
                if (p0 < 0) p0 = i;
                else if (p1 < 0) p1 = i;
            end
        checkVal("count", 64'(count), 64'(q.size()));
        checkVal("in_ready", 64'(in_ready), {62'b0, q.size() <= DEPTH - 2, q.size() <= DEPTH - 1});
        checkVal("iss_valid", 64'(iss_valid), {62'b0, p1 >= 0, p0 >= 0});
        if (p0 >= 0) checkVal("iss_data0", 64'(iss_data[DW-1:0]), 64'(q[p0].data));
        if (p1 >= 0) checkVal("iss_data1", 64'(iss_data[2*DW-1:DW]), 64'(q[p1].data));
    endtask

    function automatic ent_t slotEnt(input int k);
        ent_t e;
        e.data = in_data[k*DW +: DW];
        e.t1   = in_src1_tag[k*TW +: TW];
        e.t2   = in_src2_tag[k*TW +: TW];
        e.r1   = in_src1_rdy[k] | wbHit(e.t1);
        e.r2   = in_src2_rdy[k] | wbHit(e.t2);
        return e;
    endfunction

    task automatic modelUpdate();
        ent_t nq[$];
        int   p0 = -1;
        int   p1 = -1;
        int   n;
        if (reset) begin
            q.delete();
            model_ok = 1'b1;
            return;
        end
        if (flush) begin
            q.delete();
            return;
        end
        foreach (q[i])
            if (q[i].r1 && q[i].r2) begin
                if (p0 < 0) p0 = i;
                else if (p1 < 0) p1 = i;
            end
        foreach (q[i]) begin
            ent_t e = q[i];
            if ((i == p0 && iss_ready[0]) || (i == p1 && iss_ready[1])) continue;
            e.r1 = e.r1 | wbHit(e.t1);
            e.r2 = e.r2 | wbHit(e.t2);
            nq.push_back(e);
        end
        n = q.size();
        if (in_valid[0] && n <= DEPTH - 1) nq.push_back(slotEnt(0));
        if (in_valid[0] && in_valid[1] && n <= DEPTH - 2) nq.push_back(slotEnt(1));
        q = nq;
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic setSlot(input int k, input logic [DW-1:0] d, input logic [TW-1:0] t1,
                           input logic r1, input logic [TW-1:0] t2, input logic r2);
        in_data[k*DW +: DW]     = d;
        in_src1_tag[k*TW +: TW] = t1;
        in_src1_rdy[k]          = r1;
        in_src2_tag[k*TW +: TW] = t2;
        in_src2_rdy[k]          = r2;
    endtask

    task automatic applyStimulus(input logic [1:0] iv, input logic [1:0] wv,
                                 input logic [TW-1:0] wt0, input logic [TW-1:0] wt1,
                                 input logic [1:0] ir, input logic fl, input logic rs);
        in_valid  = iv;
        wb_valid  = wv;
        wb_tag    = {wt1, wt0};
        iss_ready = ir;
        flush     = fl;
        reset     = rs;
    endtask

    initial begin
        setSlot(0, '0, '0, 1'b0, '0, 1'b0);
        setSlot(1, '0, '0, 1'b0, '0, 1'b0);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
        step();
        checkVal("rst_count", 64'(count), 64'd0);
        checkVal("rst_in_ready", 64'(in_ready), 64'd3);
        checkVal("rst_iss_valid", 64'(iss_valid), 64'd0);

        // Two ready dispatches issue together the next cycle, then drain.
        setSlot(0, 32'hA, 6'd1, 1'b1, 6'd2, 1'b1);
        setSlot(1, 32'hB, 6'd3, 1'b1, 6'd4, 1'b1);
        applyStimulus(2'b11, 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        step();
        checkVal("ab_iss_valid", 64'(iss_valid), 64'd3);
        checkVal("ab_port0", 64'(iss_data[DW-1:0]), 64'hA);
        checkVal("ab_port1", 64'(iss_data[2*DW-1:DW]), 64'hB);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        step();
        checkVal("ab_drained", 64'(count), 64'd0);

        // Wakeup by broadcast: not issuable before, issuable the cycle after.
        setSlot(0, 32'hC, 6'd5, 1'b0, 6'd6, 1'b1);
        applyStimulus(2'b01, 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        step();
        checkVal("c_wait", 64'(iss_valid), 64'd0);
        applyStimulus(2'b00, 2'b01, 6'd5, 6'd0, 2'b11, 1'b0, 1'b0);
        step();
        checkVal("c_woken", 64'(iss_valid), 64'd1);
        checkVal("c_port0", 64'(iss_data[DW-1:0]), 64'hC);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        step();

        // Same-cycle bypass into the dispatched entry.
        setSlot(0, 32'hD, 6'd7, 1'b1, 6'd9, 1'b0);
        applyStimulus(2'b01, 2'b01, 6'd9, 6'd0, 2'b11, 1'b0, 1'b0);
        step();
        checkVal("d_bypass", 64'(iss_valid), 64'd1);
        checkVal("d_port0", 64'(iss_data[DW-1:0]), 64'hD);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        step();

        // Fill with non-ready entries to full.
        for (int i = 0; i < 3; i++) begin
            setSlot(0, 32'h100 + 2 * i, 6'd20, 1'b0, 6'd21, 1'b1);
            setSlot(1, 32'h101 + 2 * i, 6'd22, 1'b0, 6'd23, 1'b1);
            applyStimulus(2'b11, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
            step();
        end
        applyStimulus(2'b01, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        step();
        checkVal("seven_in_ready", 64'(in_ready), 64'd1);
        step();
        checkVal("full_count", 64'(count), 64'd8);
        checkVal("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(2'b11, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        step();
        checkVal("full_hold", 64'(count), 64'd8);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 1'b1, 1'b0);
        step();
        checkVal("full_flush", 64'(count), 64'd0);

        // Port 1 drains while port 0 stalls.
        setSlot(0, 32'hE0, 6'd30, 1'b0, 6'd31, 1'b1);
        setSlot(1, 32'hE1, 6'd32, 1'b1, 6'd33, 1'b1);
        applyStimulus(2'b11, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        step();
        setSlot(0, 32'hE2, 6'd34, 1'b0, 6'd35, 1'b1);
        setSlot(1, 32'hE3, 6'd36, 1'b1, 6'd37, 1'b1);
        step();
        checkVal("e_ports", 64'(iss_data), {32'hE3, 32'hE1});
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
        step();
        checkVal("e_count", 64'(count), 64'd3);
        checkVal("e_left", 64'(iss_valid), 64'd1);
        checkVal("e_port0", 64'(iss_data[DW-1:0]), 64'hE1);

        // Flush with six entries and simultaneous dispatch.
        setSlot(0, 32'hF0, 6'd40, 1'b0, 6'd41, 1'b0);
        setSlot(1, 32'hF1, 6'd42, 1'b0, 6'd43, 1'b0);
        applyStimulus(2'b11, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        step();
        applyStimulus(2'b01, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        step();
        checkVal("six_count", 64'(count), 64'd6);
        applyStimulus(2'b11, 2'b00, '0, '0, 2'b11, 1'b1, 1'b0);
        step();
        checkVal("flush_count", 64'(count), 64'd0);
        checkVal("flush_iss_valid", 64'(iss_valid), 64'd0);
        checkVal("flush_in_ready", 64'(in_ready), 64'd3);

        // Random traffic with a narrow tag space so wakeups are frequent.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++)
                setSlot(k, $urandom, 6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                        6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            applyStimulus(2'($urandom), 2'($urandom), 6'($urandom_range(0, 7)),
                          6'($urandom_range(0, 7)),
                          {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0},
                          $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
